// File: rtl/adder_parameterized_pkg.sv
// rtl/adder_parameterized_pkg.sv - shared width constants for the parameterized adder
package adder_parameterized_pkg;

    localparam int ADDER_DEFAULT_SIZE = 4;
    localparam int ADDER_MAX_SIZE     = 64;

endpackage

// File: rtl/adder_parameterized_full_adder.sv
// rtl/adder_parameterized_full_adder.sv - single-bit combinational full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/adder_parameterized.sv
// rtl/adder_parameterized.sv - ripple-carry word adder with carry-in/out and registered outputs
module adder_parameterized
    import adder_parameterized_pkg::*;
#(
    parameter int size = ADDER_DEFAULT_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    input  logic            i_c,
    output logic [size-1:0] sum,
    output logic            o_c
);

    generate
        if (size < 1 || size > ADDER_MAX_SIZE) begin : g_size_check
            $fatal(1, "adder_parameterized: size %0d outside 1..%0d", size, ADDER_MAX_SIZE);
        end
    endgenerate

    logic [size:0]   carry;
    logic [size-1:0] s_raw;

    assign carry[0] = i_c;

    for (genvar k = 0; k < size; k++) begin : g_cell
        full_adder u_fa (
            .a  (a[k]),
            .b  (b[k]),
            .ci (carry[k]),
            .s  (s_raw[k]),
            .co (carry[k+1])
        );
    end

    logic [size-1:0] sum_d, sum_q;
    logic            o_c_d, o_c_q;

    // Reset has priority over the freshly computed result, so an in-flight value is dropped.
    always_comb begin
        sum_d = s_raw;
        o_c_d = carry[size];
        if (rst) begin
            sum_d = '0;
            o_c_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        sum_q <= sum_d;
        o_c_q <= o_c_d;
    end

    assign sum = sum_q;
    assign o_c = o_c_q;

endmodule

// File: tb/tb_adder_parameterized.sv
// tb/tb_adder_parameterized.sv - self-checking bench for adder_parameterized at widths 4, 1 and 16
module tb_adder_parameterized;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  a4, b4, s4;
    logic        ci4, co4;
    logic [0:0]  a1, b1, s1;
    logic        ci1, co1;
    logic [15:0] a16, b16, s16;
    logic        ci16, co16;

    always #5 clk = ~clk;

    adder_parameterized u_dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .i_c(ci4), .sum(s4), .o_c(co4)
    );

    adder_parameterized #(.size(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .i_c(ci1), .sum(s1), .o_c(co1)
    );

    adder_parameterized #(.size(16)) u_dut16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .i_c(ci16), .sum(s16), .o_c(co16)
    );

    typedef struct {
        logic [4:0]  e4;
        logic [1:0]  e1;
        logic [16:0] e16;
    } exp_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [3:0] s;
        logic       c;
    } vec_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string nm, input logic [16:0] act, input logic [16:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {c,sum}=%h expected %h", nm, act, exp);
        end
    endtask

    // Expected values come from a size+1 bit reference sum taken at the sampling edge.
    task automatic cycle(input string nm, input bit chk4, input bit chk1, input bit chk16);
        exp_t e;
        if (rst) begin
            e.e4  = '0;
            e.e1  = '0;
            e.e16 = '0;
        end else begin
            e.e4  = {1'b0, a4} + {1'b0, b4} + {4'b0, ci4};
            e.e1  = {1'b0, a1} + {1'b0, b1} + {1'b0, ci1};
            e.e16 = {1'b0, a16} + {1'b0, b16} + {16'b0, ci16};
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        if (chk4)  check({nm, "/w4"},  {12'b0, co4, s4}, {12'b0, e.e4});
        if (chk1)  check({nm, "/w1"},  {15'b0, co1, s1}, {15'b0, e.e1});
        if (chk16) check({nm, "/w16"}, {co16, s16}, e.e16);
    endtask

    task automatic put4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        a4 = a; b4 = b; ci4 = ci;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0};
        vecs[1] = '{4'd0,  4'd0,  1'b1, 4'd1,  1'b0};
        vecs[2] = '{4'd1,  4'd1,  1'b0, 4'd2,  1'b0};
        vecs[3] = '{4'd5,  4'd3,  1'b0, 4'd8,  1'b0};
        vecs[4] = '{4'd6,  4'd8,  1'b0, 4'd14, 1'b0};
        vecs[5] = '{4'd8,  4'd9,  1'b0, 4'd1,  1'b1};
        vecs[6] = '{4'd10, 4'd10, 1'b0, 4'd4,  1'b1};
        vecs[7] = '{4'd15, 4'd15, 1'b0, 4'd14, 1'b1};
        vecs[8] = '{4'd15, 4'd0,  1'b1, 4'd0,  1'b1};

        rst = 1'b1;
        put4(4'd15, 4'd15, 1'b1);
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
        a16 = 16'hffff; b16 = 16'hffff; ci16 = 1'b1;

        for (int i = 0; i < 2; i++) begin
            cycle("reset_hold", 1, 1, 1);
            check("reset_hold_fixed", {12'b0, co4, s4}, 17'h0);
        end
        rst = 1'b0;
        cycle("reset_release", 1, 1, 1);
        check("release_fixed_w4", {12'b0, co4, s4}, 17'h1f);
        check("max_w1", {15'b0, co1, s1}, 17'h3);
        check("max_w16", {co16, s16}, 17'h1ffff);

        // Table: each result checked against its constant one cycle after its vector.
        for (int i = 0; i < 9; i++) begin
            put4(vecs[i].a, vecs[i].b, vecs[i].ci);
            cycle($sformatf("vec%0d", i), 1, 0, 0);
            check($sformatf("vec%0d_const", i), {12'b0, co4, s4}, {12'b0, vecs[i].c, vecs[i].s});
        end

        a16 = 16'd65535; b16 = 16'd1; ci16 = 1'b0;
        cycle("w16_wrap", 0, 0, 1);
        check("w16_wrap_const", {co16, s16}, 17'h10000);

        // Result holds until the next edge.
        @(negedge clk);
        check("hold_w16", {co16, s16}, 17'h10000);
        @(posedge clk);
        #1;
        q.delete();

        // Reset following a carry-producing vector, then reset arriving with 8+9 sampled.
        put4(4'd8, 4'd9, 1'b0);
        cycle("mid_pre", 1, 0, 0);
        check("mid_pre_const", {12'b0, co4, s4}, 17'h11);
        rst = 1'b1;
        cycle("mid_rst", 1, 1, 1);
        check("mid_rst_const", {12'b0, co4, s4}, 17'h0);
        rst = 1'b0;
        put4(4'd2, 4'd3, 1'b0);
        cycle("mid_after", 1, 1, 1);
        check("mid_after_const", {12'b0, co4, s4}, 17'h5);

        for (int i = 0; i < 10000; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            put4(4'($urandom), 4'($urandom), 1'($urandom));
            a1   = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
            a16  = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
            if (i % 97 == 0) begin
                a16 = 16'hffff; b16 = 16'hffff - 16'(i);
            end
            cycle($sformatf("rand%0d", i), 1, 1, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
